// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing stage: owns the PC, drives the ROM address, latches
// opcodes into the instruction register and handles SNZ skips, stall, halt/wrap.
module fetch_sequencer #(
  parameter int                   ADDR_W    = 4,
  parameter int                   INSTR_W   = 4,
  parameter int                   LAST_ADDR = 15,
  parameter int                   WRAP_EN   = 0,
  parameter logic [INSTR_W-1:0]   SNZA_OP   = 4'b1000,
  parameter logic [INSTR_W-1:0]   SNZS_OP   = 4'b0100,
  parameter int                   CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_i,
  input  logic               stall_i,
  input  logic               skip_cond_i,
  input  logic [INSTR_W-1:0] rom_data_i,
  output logic [ADDR_W-1:0]  rom_addr_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               busy_o,
  output logic               halted_o,
  output logic [CNT_W-1:0]   instr_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [INSTR_W-1:0] NOP_OP   = INSTR_W'(7);
  localparam logic [ADDR_W:0]    LAST_EXT = (ADDR_W+1)'(LAST_ADDR);
  localparam logic [ADDR_W:0]    SPAN     = (ADDR_W+1)'(LAST_ADDR + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [INSTR_W-1:0] instr;
  logic [CNT_W-1:0]  count;
  logic              valid_q, busy_q, halted_q;

  logic              skip;
  logic [ADDR_W:0]   next_pc;
  logic [ADDR_W:0]   wrapped_pc;

  // One extra bit so pc+2 at the top of the address space is seen as an overshoot.
  always_comb begin
    skip       = ((instr == SNZA_OP) || (instr == SNZS_OP)) && skip_cond_i;
    next_pc    = {1'b0, pc} + (ADDR_W+1)'(1) + (ADDR_W+1)'(skip);
    wrapped_pc = next_pc - SPAN;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= '0;
      instr    <= NOP_OP;
      count    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run_i) begin
            state  <= S_FETCH;
            pc     <= '0;
            count  <= '0;
            busy_q <= 1'b1;
          end
        end
        S_FETCH: begin
          instr   <= rom_data_i;
          state   <= S_EXEC;
          valid_q <= 1'b1;
        end
        S_EXEC: begin
          if (!stall_i) begin
            valid_q <= 1'b0;
            if (count != CNT_MAX) count <= count + CNT_W'(1);
            if (next_pc > LAST_EXT) begin
              if (WRAP_EN != 0) begin
                pc    <= wrapped_pc[ADDR_W-1:0];
                state <= S_FETCH;
              end else begin
                state    <= S_HALT;
                busy_q   <= 1'b0;
                halted_q <= 1'b1;
              end
            end else begin
              pc    <= next_pc[ADDR_W-1:0];
              state <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          if (!run_i) begin
            state    <= S_IDLE;
            halted_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rom_addr_o    = pc;
  assign pc_o          = pc;
  assign instr_o       = instr;
  assign instr_valid_o = valid_q;
  assign busy_o        = busy_q;
  assign halted_o      = halted_q;
  assign instr_count_o = count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: three instances (halt, wrap, narrow-counter wrap) fed
// from a shared ROM array; expected (pc, opcode) pairs are queued and popped per valid.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] run_v, stall_v, skc_v;
  logic [3:0] rom [16];

  logic [3:0] addr_w [3];
  logic [3:0] rdata_w[3];
  logic [3:0] instr_w[3];
  logic [3:0] pc_w   [3];
  logic       valid_w[3];
  logic       busy_w [3];
  logic       halted_w[3];
  logic [7:0] cnt_w  [3];
  logic [7:0] cnt0, cnt1;
  logic [3:0] cnt2;

  assign rdata_w[0] = rom[addr_w[0]];
  assign rdata_w[1] = rom[addr_w[1]];
  assign rdata_w[2] = rom[addr_w[2]];
  assign cnt_w[0]   = cnt0;
  assign cnt_w[1]   = cnt1;
  assign cnt_w[2]   = {4'b0000, cnt2};

  fetch_sequencer #(.WRAP_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .run_i(run_v[0]), .stall_i(stall_v[0]), .skip_cond_i(skc_v[0]),
    .rom_data_i(rdata_w[0]), .rom_addr_o(addr_w[0]), .instr_o(instr_w[0]),
    .instr_valid_o(valid_w[0]), .pc_o(pc_w[0]), .busy_o(busy_w[0]), .halted_o(halted_w[0]),
    .instr_count_o(cnt0));

  fetch_sequencer #(.WRAP_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .run_i(run_v[1]), .stall_i(stall_v[1]), .skip_cond_i(skc_v[1]),
    .rom_data_i(rdata_w[1]), .rom_addr_o(addr_w[1]), .instr_o(instr_w[1]),
    .instr_valid_o(valid_w[1]), .pc_o(pc_w[1]), .busy_o(busy_w[1]), .halted_o(halted_w[1]),
    .instr_count_o(cnt1));

  fetch_sequencer #(.WRAP_EN(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .run_i(run_v[2]), .stall_i(stall_v[2]), .skip_cond_i(skc_v[2]),
    .rom_data_i(rdata_w[2]), .rom_addr_o(addr_w[2]), .instr_o(instr_w[2]),
    .instr_valid_o(valid_w[2]), .pc_o(pc_w[2]), .busy_o(busy_w[2]), .halted_o(halted_w[2]),
    .instr_count_o(cnt2));

  typedef struct packed {
    logic [3:0] pc;
    logic [3:0] instr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    run_v   = '0;
    stall_v = '0;
    skc_v   = '0;
    rst_n   = 1'b0;
    tick();
    tick();
    rst_n   = 1'b1;
  endtask

  task automatic fill_rom(input logic [3:0] val);
    for (int i = 0; i < 16; i++) rom[i] = val;
  endtask

  // Reference sequencer: queues every (pc, opcode) the program should present.
  task automatic model(input int wrap, input logic sc, input int max_n,
                       output int fin_pc, output int n_ret);
    int   pc, nxt;
    logic skip;
    exp_t e;
    pc    = 0;
    n_ret = 0;
    while (n_ret < max_n) begin
      e.pc    = 4'(pc);
      e.instr = rom[pc];
      sb.push_back(e);
      n_ret++;
      skip = ((rom[pc] == 4'b1000) || (rom[pc] == 4'b0100)) && sc;
      nxt  = pc + 1 + int'(skip);
      if (nxt > 15) begin
        if (wrap != 0) pc = nxt - 16;
        else break;
      end else begin
        pc = nxt;
      end
    end
    fin_pc = pc;
  endtask

  task automatic run_and_collect(input int d, input logic sc, input int max_n, input int wrap,
                                 input int cnt_max, input string tag,
                                 output int fin_pc, output int n_ret);
    int   k, last, cyc, want_cnt;
    exp_t e;
    sb.delete();
    model(wrap, sc, max_n, fin_pc, n_ret);
    skc_v[d] = sc;
    run_v[d] = 1'b1;
    tick();
    run_v[d] = 1'b0;
    k = 0; last = -1; cyc = 0;
    while (sb.size() > 0 && cyc < 400) begin
      tick();
      cyc++;
      if (valid_w[d]) begin
        e = sb.pop_front();
        checks++;
        if (pc_w[d] !== e.pc || addr_w[d] !== e.pc || instr_w[d] !== e.instr) begin
          errors++;
          $display("FAIL %s[%0d] fetch: got pc=%0d addr=%0d instr=%b, want pc=%0d instr=%b",
                   tag, k, pc_w[d], addr_w[d], instr_w[d], e.pc, e.instr);
        end
        want_cnt = (k < cnt_max) ? k : cnt_max;
        checks++;
        if (cnt_w[d] !== 8'(want_cnt)) begin
          errors++;
          $display("FAIL %s[%0d] count: got %0d want %0d", tag, k, cnt_w[d], want_cnt);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 2) begin
            errors++;
            $display("FAIL %s[%0d] spacing: got %0d cycles want 2", tag, k, cyc - last);
          end
        end
        last = cyc;
        k++;
      end
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d expected fetches never seen", tag, sb.size());
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (pc_w[0] !== 4'd0 || instr_w[0] !== 4'b0111 || valid_w[0] !== 1'b0 || busy_w[0] !== 1'b0 ||
        halted_w[0] !== 1'b0 || cnt_w[0] !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: got pc=%0d instr=%b v=%b b=%b h=%b cnt=%0d want 0 0111 0 0 0 0",
               pc_w[0], instr_w[0], valid_w[0], busy_w[0], halted_w[0], cnt_w[0]);
    end
    fill_rom(4'b0011);
    rom[0] = 4'b1010;
    run_v[0] = 1'b1;
    tick();
    run_v[0] = 1'b0;
    checks++;
    if (valid_w[0] !== 1'b0 || busy_w[0] !== 1'b1 || addr_w[0] !== 4'd0) begin
      errors++;
      $display("FAIL start_fetch: got v=%b b=%b addr=%0d want v=0 b=1 addr=0",
               valid_w[0], busy_w[0], addr_w[0]);
    end
    tick();
    checks++;
    if (valid_w[0] !== 1'b1 || instr_w[0] !== 4'b1010 || addr_w[0] !== 4'd0) begin
      errors++;
      $display("FAIL first_valid: got v=%b instr=%b addr=%0d want v=1 instr=1010 addr=0",
               valid_w[0], instr_w[0], addr_w[0]);
    end
    tick();
    tick();
    checks++;
    if (valid_w[0] !== 1'b1 || pc_w[0] !== 4'd1 || cnt_w[0] !== 8'd1) begin
      errors++;
      $display("FAIL second_exec: got v=%b pc=%0d cnt=%0d want v=1 pc=1 cnt=1",
               valid_w[0], pc_w[0], cnt_w[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc_w[0] !== 4'd0 || instr_w[0] !== 4'b0111 || valid_w[0] !== 1'b0 || busy_w[0] !== 1'b0 ||
        halted_w[0] !== 1'b0 || cnt_w[0] !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: got pc=%0d instr=%b v=%b b=%b h=%b cnt=%0d want 0 0111 0 0 0 0",
               pc_w[0], instr_w[0], valid_w[0], busy_w[0], halted_w[0], cnt_w[0]);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_linear;
    int fin_pc, n_ret;
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 4'(i);
    rom[2] = 4'b1010;
    rom[3] = 4'b0010;
    run_and_collect(0, 1'b0, 100, 0, 255, "linear", fin_pc, n_ret);
    tick();
    checks++;
    if (halted_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || valid_w[0] !== 1'b0 ||
        pc_w[0] !== 4'(fin_pc) || cnt_w[0] !== 8'(n_ret)) begin
      errors++;
      $display("FAIL linear_halt: got h=%b b=%b v=%b pc=%0d cnt=%0d want h=1 b=0 v=0 pc=%0d cnt=%0d",
               halted_w[0], busy_w[0], valid_w[0], pc_w[0], cnt_w[0], fin_pc, n_ret);
    end
  endtask

  task automatic test_skip;
    logic [3:0] ops[4];
    logic       conds[4];
    int         fin_pc, n_ret;
    ops[0] = 4'b1000; conds[0] = 1'b1;
    ops[1] = 4'b1000; conds[1] = 1'b0;
    ops[2] = 4'b0100; conds[2] = 1'b1;
    ops[3] = 4'b1010; conds[3] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      do_reset();
      fill_rom(4'b0011);
      rom[4] = ops[t];
      run_and_collect(0, conds[t], 7, 0, 255, $sformatf("skip%0d", t), fin_pc, n_ret);
    end
  endtask

  task automatic test_stall;
    int cyc;
    do_reset();
    fill_rom(4'b0011);
    rom[3] = 4'b1001;
    run_v[0] = 1'b1;
    tick();
    run_v[0] = 1'b0;
    cyc = 0;
    while (!(valid_w[0] && pc_w[0] == 4'd2) && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc >= 20) begin
      errors++;
      $display("FAIL stall_reach: pc=2 exec not seen within 20 cycles, got pc=%0d", pc_w[0]);
    end
    stall_v[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid_w[0] !== 1'b1 || pc_w[0] !== 4'd2 || cnt_w[0] !== 8'd2) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b pc=%0d cnt=%0d want v=1 pc=2 cnt=2",
                 i, valid_w[0], pc_w[0], cnt_w[0]);
      end
    end
    stall_v[0] = 1'b0;
    tick();
    checks++;
    if (valid_w[0] !== 1'b0 || pc_w[0] !== 4'd3 || cnt_w[0] !== 8'd3) begin
      errors++;
      $display("FAIL stall_release: got v=%b pc=%0d cnt=%0d want v=0 pc=3 cnt=3",
               valid_w[0], pc_w[0], cnt_w[0]);
    end
    tick();
    checks++;
    if (valid_w[0] !== 1'b1 || instr_w[0] !== 4'b1001) begin
      errors++;
      $display("FAIL stall_next: got v=%b instr=%b want v=1 instr=1001", valid_w[0], instr_w[0]);
    end
  endtask

  task automatic test_boundary;
    int fin_pc, n_ret;
    do_reset();
    fill_rom(4'b0011);
    rom[14] = 4'b1000;
    run_and_collect(1, 1'b1, 17, 1, 255, "wrap14", fin_pc, n_ret);
    do_reset();
    run_and_collect(0, 1'b1, 100, 0, 255, "halt14", fin_pc, n_ret);
    run_v[0] = 1'b1;
    tick();
    checks++;
    if (halted_w[0] !== 1'b1 || pc_w[0] !== 4'(fin_pc) || cnt_w[0] !== 8'(n_ret) || fin_pc != 14) begin
      errors++;
      $display("FAIL halt14_state: got h=%b pc=%0d cnt=%0d want h=1 pc=14 cnt=%0d",
               halted_w[0], pc_w[0], cnt_w[0], n_ret);
    end
    tick();
    checks++;
    if (halted_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || pc_w[0] !== 4'd14) begin
      errors++;
      $display("FAIL halt_hold_run: got h=%b b=%b pc=%0d want h=1 b=0 pc=14",
               halted_w[0], busy_w[0], pc_w[0]);
    end
    run_v[0] = 1'b0;
    tick();
    checks++;
    if (halted_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || valid_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL halt_to_idle: got h=%b b=%b v=%b want 0 0 0", halted_w[0], busy_w[0], valid_w[0]);
    end
    run_v[0] = 1'b1;
    tick();
    run_v[0] = 1'b0;
    checks++;
    if (busy_w[0] !== 1'b1 || pc_w[0] !== 4'd0 || cnt_w[0] !== 8'd0) begin
      errors++;
      $display("FAIL restart: got b=%b pc=%0d cnt=%0d want b=1 pc=0 cnt=0",
               busy_w[0], pc_w[0], cnt_w[0]);
    end
  endtask

  task automatic test_saturation;
    int fin_pc, n_ret;
    do_reset();
    fill_rom(4'b0011);
    run_and_collect(2, 1'b0, 20, 1, 15, "sat", fin_pc, n_ret);
    tick();
    checks++;
    if (cnt_w[2] !== 8'd15 || pc_w[2] !== 4'(fin_pc)) begin
      errors++;
      $display("FAIL sat_final: got cnt=%0d pc=%0d want cnt=15 pc=%0d", cnt_w[2], pc_w[2], fin_pc);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    run_v   = '0;
    stall_v = '0;
    skc_v   = '0;
    fill_rom(4'b0000);
    test_reset();
    test_linear();
    test_skip();
    test_stall();
    test_boundary();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction fetch and sequencing stage that sits directly upstream of the 4-bit program ROM.
- Holds the program counter and drives the ROM address; captures the returned opcode into an instruction register.
- Presents one instruction at a time to the execute/control stage.
- Implements the conditional-skip opcodes (SNZ A, SNZ S), end-of-program halt or wrap, stall, and a retired-instruction counter.

Parameters:
- ADDR_W, 4, width of PC and ROM address.
- INSTR_W, 4, width of ROM opcode.
- LAST_ADDR, 15, highest program address executed before end-of-program.
- WRAP_EN, 0, 1 = PC wraps to 0 after LAST_ADDR; 0 = enter HALT.
- SNZA_OP, 4'b1000, opcode of skip-if-A-nonzero.
- SNZS_OP, 4'b0100, opcode of skip-if-S-nonzero.
- CNT_W, 8, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run_i  in  1  start/continue program execution.
- stall_i  in  1  hold current instruction in EXEC.
- skip_cond_i  in  1  from execute: tested register nonzero for the current SNZ instruction.
- rom_data_i  in  INSTR_W  opcode returned by the ROM (combinational).
- rom_addr_o  out  ADDR_W  ROM address, equal to pc_o.
- instr_o  out  INSTR_W  instruction register.
- instr_valid_o  out  1  instr_o valid for execute this cycle.
- pc_o  out  ADDR_W  current program counter.
- busy_o  out  1  state is FETCH or EXEC.
- halted_o  out  1  state is HALT.
- instr_count_o  out  CNT_W  number of retired instructions, saturating.

Behaviour:
- Reset is asynchronous and active-low: the clock is clk and the reset is rst_n, and all state clears immediately on rst_n low, independent of clk.
  - Reset values: state=IDLE, pc=0, instr=4'b0111 (CLR/NOP), instr_valid_o=0, busy_o=0, halted_o=0, instr_count_o=0.
  - Reset asserted mid-instruction discards that instruction: no count, no PC update.
- rom_addr_o = pc_o at all times. The ROM is combinational, so rom_data_i is sampled on the same edge.
- FSM, 4 states:
  - IDLE: outputs quiet. If run_i=1 -> FETCH, with pc reset to 0 and instr_count_o cleared.
  - FETCH: on the edge, instr <= rom_data_i; -> EXEC. Takes 1 cycle.
  - EXEC: instr_valid_o=1.
    - If stall_i=1: remain in EXEC, all registers held.
    - Otherwise the instruction retires this edge: instr_count_o increments, saturating at 2^CNT_W-1.
    - skip = (instr==SNZA_OP || instr==SNZS_OP) && skip_cond_i. skip_cond_i is ignored for all other opcodes.
    - next = pc + 1 + skip, computed in ADDR_W+1 bits.
    - If next > LAST_ADDR: with WRAP_EN=1, pc <= next - (LAST_ADDR+1) -> FETCH; with WRAP_EN=0, pc holds -> HALT.
    - Else pc <= next -> FETCH.
  - HALT: halted_o=1, pc and instr_count_o held. run_i=0 -> IDLE. run_i=1 stays HALT.
- run_i deasserted during FETCH/EXEC has no effect; execution continues until HALT. run_i is only sampled in IDLE and HALT.
- Throughput: 2 cycles per unstalled instruction. First instr_valid_o is 2 cycles after the run_i edge (IDLE->FETCH->EXEC).
- A skip at pc=LAST_ADDR-1 or at LAST_ADDR overshoots the end: halt with WRAP_EN=0, or wrap to 0/1 with WRAP_EN=1.
- Outputs are registered, or decoded from registered state only; no combinational path from inputs to outputs.

Test Plan:
- Reset/start: rst_n low mid-EXEC -> all outputs return to reset values in the same cycle. Release, run_i=1 for 1 cycle -> rom_addr_o=0, instr_valid_o=1 at cycle 2 with instr_o=rom[0].
- Linear program, ROM[0..15]=0000,0001,1010,0010,..., skip_cond_i=0, WRAP_EN=0 -> pc steps 0..15, 16 valid pulses 2 cycles apart, halted_o=1, instr_count_o=16.
- Skip taken: ROM[4]=1000 with skip_cond_i=1 in EXEC -> next pc=6, address 5 never fetched. Same with skip_cond_i=0 -> pc=5. ROM[4]=0100 behaves the same. ROM[4]=1010 with skip_cond_i=1 -> pc=5.
- Stall: stall_i=1 for 3 cycles during EXEC of pc=2 -> instr_valid_o held high 4 cycles, pc and count unchanged until release, then pc=3.
- Boundary: SNZ at pc=14 with skip, LAST_ADDR=15, WRAP_EN=1 -> pc=0. With WRAP_EN=0 -> HALT, pc=14. HALT with run_i=0 -> IDLE. Then run_i=1 -> pc=0, count=0.
- Counter saturation, CNT_W=4, WRAP_EN=1: run 20 instructions -> instr_count_o sticks at 15.
